// File: rtl/inst_rom_server.sv
// Instruction memory for the fetch stage: registered one-cycle reads plus a
// word-serial load port that stalls fetch while the memory is being filled.
module inst_rom_server #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] program_counter,
    input  logic        chip_enable,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic        address_fault,
    output logic        stall,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done,
    output logic        load_overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pointer;
    logic [31:0]             mem [DEPTH];

    logic                    fetch_legal;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    load_accept;

    // Legal means word aligned and no address bits above the memory range.
    assign fetch_legal = (program_counter[1:0] == 2'b00) &&
                         ((program_counter >> (ADDR_WIDTH + 2)) == 32'd0);
    assign fetch_addr  = program_counter[ADDR_WIDTH+1:2];
    assign load_accept = (state == LOAD) && load_valid;

    assign stall      = (state != IDLE);
    assign load_ready = (state == LOAD);
    assign load_done  = (state == DONE);

    // NOTE: the storage array has no reset branch so it maps onto plain RAM;
    // contents survive reset, which also keeps words written before a mid-load reset.
    always_ff @(posedge clock) begin
        if (!reset && load_accept) begin
            mem[pointer] <= load_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            pointer           <= '0;
            load_overflow     <= 1'b0;
            instruction       <= '0;
            instruction_valid <= 1'b0;
            address_fault     <= 1'b0;
        end else begin
            instruction       <= '0;
            instruction_valid <= 1'b0;
            address_fault     <= 1'b0;

            if (state == IDLE && chip_enable) begin
                if (fetch_legal) begin
                    instruction       <= mem[fetch_addr];
                    instruction_valid <= 1'b1;
                end else begin
                    address_fault     <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (load_start) begin
                        state         <= LOAD;
                        pointer       <= '0;
                        load_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_accept) begin
                        pointer <= pointer + 1'b1;
                        if (pointer == {ADDR_WIDTH{1'b1}}) begin
                            load_overflow <= 1'b1;
                        end
                        if (load_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_server.sv
// Randomised scoreboard bench for inst_rom_server against a behavioural model.
module tb_inst_rom_server;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] program_counter = '0;
    logic        chip_enable = 1'b0;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        address_fault;
    logic        stall;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic        load_overflow;

    always #5 clock = ~clock;

    inst_rom_server #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .program_counter(program_counter), .chip_enable(chip_enable),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .address_fault(address_fault), .stall(stall),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_overflow(load_overflow)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid, fault, stall, ready, done, ovf;
        bit          instr_known;
    } exp_t;

    typedef enum {M_IDLE, M_LOAD, M_DONE} mode_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          known [DEPTH];
    mode_t       ref_mode = M_IDLE;
    int          ref_ptr = 0;
    bit          ref_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Expected post-edge outputs from the pre-edge inputs and model contents.
    task automatic model_step();
        exp_t e;
        int   a;
        e = '{instr: '0, valid: 0, fault: 0, stall: 0, ready: 0, done: 0, ovf: 0, instr_known: 1};
        if (reset) begin
            ref_mode = M_IDLE;
            ref_ptr  = 0;
            ref_ovf  = 1'b0;
        end else begin
            if (ref_mode == M_IDLE && chip_enable) begin
                if (program_counter % 4 == 0 && program_counter < 32'(DEPTH * 4)) begin
                    a             = int'(program_counter / 4);
                    e.valid       = 1'b1;
                    e.instr       = ref_mem[a];
                    e.instr_known = known[a];
                end else begin
                    e.fault = 1'b1;
                end
            end
            if (ref_mode == M_IDLE && load_start) begin
                ref_mode = M_LOAD;
                ref_ptr  = 0;
                ref_ovf  = 1'b0;
            end else if (ref_mode == M_LOAD && load_valid) begin
                ref_mem[ref_ptr] = load_data;
                known[ref_ptr]   = 1'b1;
                if (ref_ptr == DEPTH - 1) ref_ovf = 1'b1;
                ref_ptr = (ref_ptr + 1) % DEPTH;
                if (load_last) ref_mode = M_DONE;
            end else if (ref_mode == M_DONE) begin
                ref_mode = M_IDLE;
            end
        end
        e.stall = (ref_mode != M_IDLE);
        e.ready = (ref_mode == M_LOAD);
        e.done  = (ref_mode == M_DONE);
        e.ovf   = ref_ovf;
        exp_q.push_back(e);
    endtask

    always @(posedge clock) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.instr_known || !e.valid) check("instruction", instruction, e.instr);
            check("instruction_valid", 32'(instruction_valid), 32'(e.valid));
            check("address_fault", 32'(address_fault), 32'(e.fault));
            check("stall", 32'(stall), 32'(e.stall));
            check("load_ready", 32'(load_ready), 32'(e.ready));
            check("load_done", 32'(load_done), 32'(e.done));
            check("load_overflow", 32'(load_overflow), 32'(e.ovf));
        end
    end

    task automatic step();
        model_step();
        @(posedge clock);
        #2;
    endtask

    task automatic fetch(input logic [31:0] a);
        chip_enable = 1'b1;
        program_counter = a;
        step();
        chip_enable = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] w[$]);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        foreach (w[i]) begin
            load_valid = 1'b1;
            load_data  = w[i];
            load_last  = (i == w.size() - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [31:0] words[$];

        // Reset state.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Preload mem[3] and fetch PC 0x0C.
        load_words('{32'h1, 32'h2, 32'h3, 32'hDEADBEEF});
        fetch(32'h0C);

        // Wrap: DEPTH+1 words, final word lands at mem[0].
        words.delete();
        for (int i = 0; i <= DEPTH; i++) words.push_back($urandom);
        load_words(words);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'hFFC);

        // Fresh load clears overflow; then back-to-back fetches.
        load_words('{32'h11, 32'h22, 32'h33});
        chip_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            program_counter = 32'(i * 4);
            step();
        end
        chip_enable = 1'b0;
        step();

        // Faults.
        fetch(32'h2);
        fetch(32'h1000);
        fetch(32'hFFC);
        fetch(32'hFFFF_FFFC);

        // Fetch held throughout a load with gaps in load_valid.
        chip_enable = 1'b1;
        program_counter = 32'h8;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = 32'hA000 + 32'(i);
            load_last  = (i == 4);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        chip_enable = 1'b0;

        // Reset in the middle of a load; written words persist.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hCAFE_0001;
        step();
        load_data  = 32'hCAFE_0002;
        step();
        load_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        fetch(32'h0);
        fetch(32'h4);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            chip_enable = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       program_counter = 32'($urandom_range(0, DEPTH - 1)) << 2;
                1:       program_counter = 32'($urandom_range(0, 7)) << 2;
                2:       program_counter = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                default: program_counter = $urandom | 32'h1000;
            endcase
            load_start = ($urandom_range(0, 19) == 0);
            load_valid = $urandom_range(0, 1);
            load_data  = $urandom;
            load_last  = ($urandom_range(0, 7) == 0);
            step();
        end
        reset       = 1'b0;
        chip_enable = 1'b0;
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        for (int i = 0; i < 4; i++) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_rom_server.md
# inst_rom_server

Instruction-memory responder at the far end of the fetch interface. It accepts the fetch stage's `program_counter`/`chip_enable` request and returns the addressed 32-bit instruction one cycle later. A word-serial load port lets a host or bootloader fill the memory at run time. While a load is in progress the block asserts `stall` and suppresses fetch responses.

## Interface
- `ADDR_WIDTH`, 10: word-address width; memory depth `DEPTH = 2**ADDR_WIDTH` words.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `program_counter` input 32: byte address from fetch stage.
- `chip_enable` input 1: fetch request valid this cycle.
- `instruction` output 32: fetched word, registered.
- `instruction_valid` output 1: `instruction` holds a legal fetched word.
- `address_fault` output 1: previous request was misaligned or out of range.
- `stall` output 1: memory busy loading; fetch must hold its PC.
- `load_start` input 1: begin a load at word 0.
- `load_valid` input 1: `load_data` is presented.
- `load_data` input 32: word to write.
- `load_last` input 1: qualifies the final word of the load.
- `load_ready` output 1: block accepts a load word this cycle.
- `load_done` output 1: one-cycle pulse after the final word is written.
- `load_overflow` output 1: sticky; the write pointer wrapped during the current or last load.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE -> LOAD on `load_start`.
  - LOAD -> DONE on an accepted word with `load_last=1`.
  - DONE -> IDLE unconditionally after one cycle.
- `load_start` resets the write pointer to 0 and clears `load_overflow`. `load_start` is ignored in LOAD and DONE.
- LOAD: `load_ready=1`. A word is accepted when `load_valid & load_ready`; it writes `mem[pointer]` and increments `pointer` modulo DEPTH.
  - An accepted word at `pointer=DEPTH-1` wraps the pointer to 0 and sets `load_overflow=1`. The load continues.
- `load_ready=0` in IDLE and DONE. `load_valid` is ignored there.
- `stall = (state != IDLE)`, combinational from state.
- Fetch path in IDLE with `chip_enable=1`:
  - Legal request: `program_counter[1:0]==0` and `program_counter[31:ADDR_WIDTH+2]==0`. Next cycle: `instruction = mem[program_counter[ADDR_WIDTH+1:2]]`, `instruction_valid=1`, `address_fault=0`.
  - Illegal request: next cycle `instruction=0`, `instruction_valid=0`, `address_fault=1`.
- Any of the following gives next-cycle `instruction=0`, `instruction_valid=0`, `address_fault=0`:
  - `chip_enable=0`;
  - state LOAD or DONE (regardless of `chip_enable`).
- Memory contents are not reset. Unwritten words read as whatever the storage holds; the bench must preload before checking.

## Timing
- Reset values:
  - `instruction=0`, `instruction_valid=0`, `address_fault=0`;
  - `load_done=0`, `load_overflow=0`, `load_ready=0`, `stall=0`;
  - state IDLE, pointer 0.
- Read latency is exactly 1 cycle: a request sampled on edge N produces outputs valid after edge N, stable through edge N+1. The result is the registered value of that request; back-to-back requests give one response per cycle.
- Write latency: a word accepted at edge N is readable by a request sampled at edge N+1 or later. Reads are only possible in IDLE, so any load completes before its words are read.
- `load_done` is high exactly the cycle the state is DONE.
- Simultaneous events:
  - `load_start` and a legal fetch in the same IDLE cycle: the fetch is served (valid response next cycle) and the state moves to LOAD.
  - `load_last` accepted at `pointer=DEPTH-1`: the word is written, the pointer wraps, `load_overflow` is set, and the state goes to DONE.
- Reset mid-load: state returns to IDLE, outputs go to reset values, and words already written are retained.

## Test plan
- Reset then fetch: preload `mem[3]=0xDEADBEEF`; `chip_enable=1`, PC=0x0C -> next cycle `instruction=0xDEADBEEF`, `valid=1`, `fault=0`.
- Load and run: `load_start`, then words 0x11, 0x22, 0x33 with `load_last` on 0x33 -> `load_done` pulses 1 cycle, `stall` high from the cycle after `load_start` through DONE. Then PC=0,4,8 back-to-back -> 0x11, 0x22, 0x33 on consecutive cycles.
- Faults (`ADDR_WIDTH=10`):
  - PC=0x02 -> `fault=1`, `valid=0`, `instruction=0`.
  - PC=0x1000 -> `fault=1`.
  - PC=0xFFC -> valid read of `mem[1023]`.
- Fetch during load: `chip_enable=1` held throughout LOAD -> `valid=0`, `fault=0`, `instruction=0` every cycle until IDLE.
- Wrap: with `ADDR_WIDTH=2`, load 5 words A..E (`last` on E) -> `load_overflow=1`; `mem[0]=E`, `mem[1..3]=B,C,D`. A new `load_start` clears `load_overflow`.
- Reset mid-load: 2 words accepted, assert `reset` -> state IDLE, `stall=0`, `load_ready=0`, both words readable afterwards.
